// File: rtl/pe_conv_ctrl_pkg.sv
// Shared definitions for the 3x3 convolution window controller: FSM encoding,
// PE mode codes, window geometry constants and tap-offset helpers.
package pe_conv_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_DRAIN = 2'b10,
        ST_OUT   = 2'b11
    } state_t;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_ACC  = 2'b01;

    localparam int KTAPS         = 9;
    localparam int DRAIN_TIMEOUT = 4;

    function automatic logic [1:0] tap_row_off(input logic [3:0] k);
        return 2'(k / 4'd3);
    endfunction

    function automatic logic [1:0] tap_col_off(input logic [3:0] k);
        return 2'(k % 4'd3);
    endfunction

endpackage

// File: rtl/pe_conv_ctrl_tap_addr_gen.sv
// Tap address generator: maps window origin and tap index k onto the ifmap
// linear address and the filter tap index.
module tap_addr_gen
    import pe_conv_ctrl_pkg::*;
#(
    parameter int IMG_W = 8,
    parameter int AW    = 8
) (
    input  logic [AW-1:0] row,
    input  logic [AW-1:0] col,
    input  logic [3:0]    k,
    output logic [AW-1:0] ifmap_addr,
    output logic [3:0]    filt_addr
);

    localparam int FW = 2 * AW + 4;

    logic [FW-1:0] full_addr_s;

    // Row-major address of tap k; wide intermediate, truncated to AW.
    always_comb begin
        full_addr_s = (FW'(row) + FW'(tap_row_off(k))) * FW'(IMG_W)
                      + FW'(col) + FW'(tap_col_off(k));
        ifmap_addr  = full_addr_s[AW-1:0];
        filt_addr   = k;
    end

endmodule

// File: rtl/pe_conv_ctrl.sv
// Controller that streams one 3x3 ifmap window and its filter taps into an
// external PE, then hands the PE result off over a valid/ready interface.
module pe_conv_ctrl
    import pe_conv_ctrl_pkg::*;
#(
    parameter int IMG_W = 8,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] start_row,
    input  logic [AW-1:0] start_col,
    output logic          busy,
    output logic [AW-1:0] ifmap_addr,
    input  logic [7:0]    ifmap_rdata,
    output logic [3:0]    filt_addr,
    input  logic [7:0]    filt_rdata,
    output logic [7:0]    pe_in,
    output logic [7:0]    pe_filter,
    output logic [1:0]    pe_mode,
    input  logic [7:0]    pe_out,
    input  logic          pe_count_9,
    output logic [7:0]    res_data,
    output logic          res_valid,
    input  logic          res_ready,
    output logic          err
);

    localparam logic [AW-1:0] MAX_ORG = AW'(IMG_W - 3);

    state_t        state_r, next_state_s;
    logic [3:0]    k_r;
    logic [AW-1:0] row_r, col_r;
    logic [2:0]    drain_cnt_r;
    logic          busy_r, res_valid_r, err_r;
    logic [7:0]    res_data_r;
    logic [1:0]    pe_mode_r;
    logic [AW-1:0] ifmap_addr_r;
    logic [3:0]    filt_addr_r;

    logic [AW-1:0] gen_row_s, gen_col_s, gen_addr_s;
    logic [3:0]    gen_k_s, gen_filt_s;
    logic          origin_ok_s, accept_s, reject_s, capture_s, timeout_s, handoff_s;

    assign origin_ok_s = (start_row <= MAX_ORG) && (start_col <= MAX_ORG);

    // Addresses are produced one tap ahead so each one is on the port during its FETCH cycle.
    tap_addr_gen #(.IMG_W(IMG_W), .AW(AW)) u_tap_addr_gen (
        .row        (gen_row_s),
        .col        (gen_col_s),
        .k          (gen_k_s),
        .ifmap_addr (gen_addr_s),
        .filt_addr  (gen_filt_s)
    );

    // Next-state and event decode.
    always_comb begin
        next_state_s = state_r;
        gen_row_s    = row_r;
        gen_col_s    = col_r;
        gen_k_s      = k_r + 4'd1;
        accept_s     = 1'b0;
        reject_s     = 1'b0;
        capture_s    = 1'b0;
        timeout_s    = 1'b0;
        handoff_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                gen_row_s = start_row;
                gen_col_s = start_col;
                gen_k_s   = 4'd0;
                if (start && origin_ok_s) begin
                    accept_s     = 1'b1;
                    next_state_s = ST_FETCH;
                end else if (start) begin
                    reject_s     = 1'b1;
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (k_r == 4'(KTAPS - 1)) begin
                    next_state_s = ST_DRAIN;
                end else begin
                    next_state_s = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (pe_count_9) begin
                    capture_s    = 1'b1;
                    next_state_s = ST_OUT;
                end else if (drain_cnt_r == 3'(DRAIN_TIMEOUT - 1)) begin
                    timeout_s    = 1'b1;
                    next_state_s = ST_OUT;
                end else begin
                    next_state_s = ST_DRAIN;
                end
            end
            ST_OUT: begin
                if (res_ready) begin
                    handoff_s    = 1'b1;
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_OUT;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Registered datapath and outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_r          <= 4'd0;
            row_r        <= '0;
            col_r        <= '0;
            drain_cnt_r  <= 3'd0;
            busy_r       <= 1'b0;
            res_valid_r  <= 1'b0;
            res_data_r   <= 8'h00;
            err_r        <= 1'b0;
            pe_mode_r    <= MODE_HOLD;
            ifmap_addr_r <= '0;
            filt_addr_r  <= 4'd0;
        end else begin
            if (accept_s) begin
                row_r        <= start_row;
                col_r        <= start_col;
                k_r          <= 4'd0;
                ifmap_addr_r <= gen_addr_s;
                filt_addr_r  <= gen_filt_s;
            end else if (state_r == ST_FETCH && k_r != 4'(KTAPS - 1)) begin
                k_r          <= k_r + 4'd1;
                ifmap_addr_r <= gen_addr_s;
                filt_addr_r  <= gen_filt_s;
            end
            // Read data lands one cycle after each FETCH cycle, so the PE accumulates then.
            pe_mode_r   <= (state_r == ST_FETCH) ? MODE_ACC : MODE_HOLD;
            drain_cnt_r <= (state_r == ST_DRAIN) ? drain_cnt_r + 3'd1 : 3'd0;
            err_r       <= reject_s | timeout_s;
            busy_r      <= (next_state_s != ST_IDLE);
            if (capture_s) begin
                res_data_r  <= pe_out;
                res_valid_r <= 1'b1;
            end else if (timeout_s) begin
                res_data_r  <= 8'h00;
                res_valid_r <= 1'b1;
            end else if (handoff_s) begin
                res_valid_r <= 1'b0;
            end
        end
    end

    assign busy       = busy_r;
    assign ifmap_addr = ifmap_addr_r;
    assign filt_addr  = filt_addr_r;
    assign pe_in      = ifmap_rdata;
    assign pe_filter  = filt_rdata;
    assign pe_mode    = pe_mode_r;
    assign res_data   = res_data_r;
    assign res_valid  = res_valid_r;
    assign err        = err_r;

endmodule

// File: tb/tb_pe_conv_ctrl.sv
// Bench for pe_conv_ctrl: behavioural memories and PE around the controller,
// results predicted by direct window dot products on the stored arrays.
module tb_pe_conv_ctrl;

    localparam int IMG_W = 8;
    localparam int AW    = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] start_row = '0;
    logic [AW-1:0] start_col = '0;
    logic          res_ready = 1'b0;
    logic          tie0 = 1'b0;
    logic          busy, res_valid, err;
    logic [AW-1:0] ifmap_addr;
    logic [3:0]    filt_addr;
    logic [7:0]    ifmap_rdata, filt_rdata, pe_in, pe_filter, pe_out, res_data;
    logic [1:0]    pe_mode;
    logic          pe_count_9;

    logic [7:0] ifmap_mem [0:255];
    logic [7:0] filt_mem  [0:15];
    logic [7:0] pe_acc;
    logic [3:0] pe_cnt;

    int compared   = 0;
    int mismatched = 0;

    pe_conv_ctrl #(.IMG_W(IMG_W), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .start_row(start_row), .start_col(start_col),
        .busy(busy), .ifmap_addr(ifmap_addr), .ifmap_rdata(ifmap_rdata),
        .filt_addr(filt_addr), .filt_rdata(filt_rdata), .pe_in(pe_in), .pe_filter(pe_filter),
        .pe_mode(pe_mode), .pe_out(pe_out), .pe_count_9(pe_count_9),
        .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready), .err(err)
    );

    always #5 clk = ~clk;

    // Synchronous-read memories: data valid one cycle after address.
    always @(posedge clk) begin
        ifmap_rdata <= ifmap_mem[ifmap_addr];
        filt_rdata  <= filt_mem[filt_addr];
    end

    // One-stage PE: accumulates while mode is ACC, clears on HOLD.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pe_acc <= 8'h00;
            pe_cnt <= 4'd0;
        end else if (pe_mode == 2'b01) begin
            pe_acc <= pe_acc + pe_in * pe_filter;
            pe_cnt <= pe_cnt + 4'd1;
        end else begin
            pe_acc <= 8'h00;
            pe_cnt <= 4'd0;
        end
    end
    assign pe_out     = pe_acc;
    assign pe_count_9 = (pe_cnt == 4'd9) && !tie0;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_ones();
        for (int i = 0; i < 256; i++) ifmap_mem[i] = 8'd1;
        for (int i = 0; i < 16; i++) filt_mem[i] = 8'd1;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 256; i++) ifmap_mem[i] = 8'($urandom);
        for (int i = 0; i < 16; i++) filt_mem[i] = 8'($urandom);
    endtask

    function automatic logic [7:0] ref_result(input int row, input int col);
        int s = 0;
        for (int k = 0; k < 9; k++)
            s += int'(ifmap_mem[(row + k / 3) * IMG_W + col + k % 3]) * int'(filt_mem[k]);
        return 8'(s);
    endfunction

    task automatic run_window(input int row, input int col, input int hold, input bit to_case);
        logic [7:0] exp_d;
        int t;
        bit got;
        exp_d     = to_case ? 8'h00 : ref_result(row, col);
        tie0      = to_case;
        res_ready = (hold == 0);
        start     = 1'b1;
        start_row = AW'(row);
        start_col = AW'(col);
        tick();
        start = 1'b0;
        t     = 1;
        check("busy_on_accept", busy, 1);
        for (int k = 0; k < 9; k++) begin
            check("ifmap_addr", ifmap_addr, (row + k / 3) * IMG_W + col + k % 3);
            check("filt_addr", filt_addr, k);
            check("pe_mode_fetch", pe_mode, (k == 0) ? 0 : 1);
            tick();
            t++;
        end
        check("pe_mode_last_data", pe_mode, 1);
        got = 1'b0;
        while (!got && t < 30) begin
            if (res_valid) begin
                got = 1'b1;
            end else begin
                check("err_quiet", err, 0);
                check("busy_drain", busy, 1);
                tick();
                t++;
            end
        end
        check("result_latency", t, to_case ? 14 : 12);
        if (got) begin
            check("err_at_result", err, to_case);
            check("res_data", res_data, exp_d);
            for (int h = 0; h < hold; h++) begin
                if (h == 0) begin
                    start     = 1'b1;
                    start_row = AW'($urandom_range(0, IMG_W - 3));
                    start_col = AW'($urandom_range(0, IMG_W - 3));
                end
                tick();
                start = 1'b0;
                check("res_valid_held", res_valid, 1);
                check("res_data_held", res_data, exp_d);
                check("busy_held", busy, 1);
                check("err_held", err, 0);
            end
            res_ready = 1'b1;
            tick();
            check("res_valid_cleared", res_valid, 0);
            check("busy_cleared", busy, 0);
            check("err_after", err, 0);
            tick();
            check("busy_stays_idle", busy, 0);
            check("addr_unchanged", ifmap_addr, (row + 2) * IMG_W + col + 2);
        end
        res_ready = 1'b0;
        tie0      = 1'b0;
    endtask

    task automatic reject(input int row, input int col);
        logic [AW-1:0] prev;
        prev      = ifmap_addr;
        start     = 1'b1;
        start_row = AW'(row);
        start_col = AW'(col);
        tick();
        start = 1'b0;
        check("reject_err", err, 1);
        check("reject_busy", busy, 0);
        check("reject_addr", ifmap_addr, prev);
        tick();
        check("reject_err_pulse", err, 0);
        check("reject_busy2", busy, 0);
        check("reject_addr2", ifmap_addr, prev);
        check("reject_mode", pe_mode, 0);
    endtask

    initial begin
        fill_ones();
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_err", err, 0);
        check("rst_pe_mode", pe_mode, 0);
        check("rst_ifmap_addr", ifmap_addr, 0);
        check("rst_filt_addr", filt_addr, 0);
        rst = 1'b0;
        tick();

        run_window(0, 0, 0, 1'b0);
        fill_random();
        run_window(2, 3, 0, 1'b0);
        reject(6, 0);
        reject(0, 6);
        reject(5, 200);
        run_window(5, 5, 5, 1'b0);
        run_window(1, 4, 0, 1'b1);
        run_window(3, 2, 2, 1'b1);

        fill_random();
        start     = 1'b1;
        start_row = AW'(1);
        start_col = AW'(1);
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("tap4_addr", ifmap_addr, 18);
        rst = 1'b1;
        tick();
        check("abort_busy", busy, 0);
        check("abort_mode", pe_mode, 0);
        check("abort_valid", res_valid, 0);
        check("abort_err", err, 0);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            check("abort_no_result", res_valid | err | busy, 0);
        end
        run_window(1, 1, 1, 1'b0);

        for (int n = 0; n < 8; n++) begin
            fill_random();
            run_window($urandom_range(0, IMG_W - 3), $urandom_range(0, IMG_W - 3),
                       $urandom_range(0, 3), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pe_conv_ctrl.md
PE_CONV_CTRL -- requirements
Module: pe_conv_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 8: ifmap row width in pixels (square ifmap, IMG_W x IMG_W).
REQ-002 SHALL have parameter AW, default 8: ifmap address width; IMG_W*IMG_W SHALL be <= 2**AW.
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  one-cycle request to compute one 3x3 window.
REQ-006 start_row, start_col  in  AW each  window origin (top-left pixel), sampled on accepted start.
REQ-007 busy  out  1  high from accepted start until result handed off.
REQ-008 ifmap_addr  out  AW  ifmap read address; ifmap_rdata  in  8  read data, valid one cycle after address.
REQ-009 filt_addr  out  4  filter tap index 0..8; filt_rdata  in  8  tap data, valid one cycle after address.
REQ-010 pe_in, pe_filter  out  8 each  operands to PE; pe_mode  out  2  PE mode (2'b00 hold/clear, 2'b01 accumulate).
REQ-011 pe_out  in  8  PE result; pe_count_9  in  1  PE ninth-product flag.
REQ-012 res_data  out  8; res_valid  out  1; res_ready  in  1  result handshake.
REQ-013 err  out  1  one-cycle pulse: rejected origin or drain timeout.

Function
REQ-014 FSM states SHALL be IDLE, FETCH, DRAIN, OUT.
REQ-015 IDLE: start accepted only if start_row <= IMG_W-3 and start_col <= IMG_W-3; otherwise err pulses next cycle and state stays IDLE.
REQ-016 Accepted start SHALL latch origin, clear tap counter k, go to FETCH next cycle; start while busy SHALL be ignored.
REQ-017 FETCH: for k = 0..8 on consecutive cycles, ifmap_addr = (start_row + k/3)*IMG_W + start_col + k%3 and filt_addr = k; widths truncated to AW.
REQ-018 pe_in = ifmap_rdata and pe_filter = filt_rdata combinationally; pe_mode = 2'b01 for exactly the 9 cycles one cycle after each address issue, else 2'b00.
REQ-019 After k = 8 issues, state SHALL go to DRAIN; pe_mode remains 2'b01 for the final data cycle, which falls in the first DRAIN cycle.
REQ-020 DRAIN: on the first cycle pe_count_9 = 1, capture pe_out into res_data, assert res_valid, go to OUT.
REQ-021 If pe_count_9 not seen within 4 cycles of entering DRAIN, pulse err, set res_data = 8'h00, res_valid = 1, go to OUT.
REQ-022 OUT: res_valid and res_data held stable until res_ready = 1; on that cycle transfer occurs, next cycle res_valid = 0, busy = 0, state IDLE.
REQ-023 res_ready already high on entry to OUT SHALL complete transfer on the first OUT cycle; no extra latency.
REQ-024 Nominal latency: start accepted at cycle 0 -> res_valid rises no earlier than cycle 12 (9 fetch + 1 read + PE pipeline).
REQ-025 Arithmetic (multiply, 8-bit accumulate wrap) SHALL remain in the PE; controller performs only address arithmetic.

Reset
REQ-026 On rst: state IDLE, k = 0, busy 0, res_valid 0, res_data 8'h00, err 0, pe_mode 2'b00, ifmap_addr 0, filt_addr 0.
REQ-027 Reset asserted mid-operation SHALL abort immediately with no result and no err; PE is reset by the same rst.

Structure
REQ-028 Shared package SHALL hold FSM state encoding, PE mode constants (MODE_HOLD = 2'b00, MODE_ACC = 2'b01), KTAPS = 9, DRAIN_TIMEOUT = 4.
REQ-029 One sub-module, tap_addr_gen, SHALL compute ifmap_addr and filt_addr from origin and k; the PE stays outside this block.

Verification
REQ-030 IMG_W = 8, all pixels 1, all taps 1, origin (0,0), res_ready = 1 -> one res_valid pulse with res_data 9; err never asserted.
REQ-031 Origin (2,3) -> ifmap_addr sequence 19,20,21,27,28,29,35,36,37 with filt_addr 0..8 on consecutive cycles.
REQ-032 Origin (6,0) with IMG_W = 8 -> err pulse, busy stays 0, no ifmap_addr activity.
REQ-033 res_ready held low 5 cycles after res_valid -> res_data stable for 6 cycles; second start during that time ignored.
REQ-034 pe_count_9 tied 0 -> err pulse 4 cycles after DRAIN entry, res_valid with res_data 8'h00.
REQ-035 rst asserted at tap 4 -> next cycle busy 0, pe_mode 2'b00, no res_valid; a new start then completes normally.
